// File: rtl/thumb_encoder.sv
// thumb_encoder: turns decode-stage micro-ops into 16-bit Thumb halfwords, buffered in a 2-entry FIFO.
// Define ENC_BRANCH_EN to encode conditional (B<cond>) and unconditional (B) branches from NOP micro-ops.
module thumb_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  uop,
    input  logic        num_to_rhs,
    input  logic [31:0] num,
    input  logic [3:0]  sel_p0,
    input  logic [3:0]  sel_p1,
    input  logic [3:0]  sel_in,
    input  logic [3:0]  branch_cond,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] instruction,
    output logic [7:0]  addr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [4:0] UOP_NOP = 5'd0;
    localparam logic [4:0] UOP_ADD = 5'd1;
    localparam logic [4:0] UOP_SUB = 5'd2;
    localparam logic [4:0] UOP_LSL = 5'd3;
    localparam logic [4:0] UOP_MOV = 5'd4;
    localparam logic [4:0] UOP_CMP = 5'd5;
    localparam logic [4:0] UOP_EOR = 5'd6;
    localparam logic [4:0] UOP_LDR = 5'd7;
    localparam logic [4:0] UOP_STR = 5'd8;

    logic        enc_ok;
    logic [15:0] enc_word;
    logic        is_sub;
    logic        num_le7, num_le31, num_le255;

    assign is_sub    = (uop == UOP_SUB);
    assign num_le7   = (num[31:3] == '0);
    assign num_le31  = (num[31:5] == '0);
    assign num_le255 = (num[31:8] == '0);

`ifdef ENC_BRANCH_EN
    logic num_simm8, num_simm11;
    // Signed range holds when every bit above the field matches the field's sign bit.
    assign num_simm8  = (&num[31:7])  || (num[31:7]  == '0);
    assign num_simm11 = (&num[31:10]) || (num[31:10] == '0);
`endif

    // NOTE: defaults first so every path through the case assigns both outputs; no latch is inferred.
    always_comb begin
        enc_ok   = 1'b0;
        enc_word = 16'h0000;
        case (uop)
            UOP_ADD, UOP_SUB: begin
                if (!num_to_rhs) begin
                    enc_ok   = !sel_p0[3] && !sel_p1[3] && !sel_in[3];
                    enc_word = {6'b000110, is_sub, sel_p0[2:0], sel_p1[2:0], sel_in[2:0]};
                end else if (num_le7) begin
                    enc_ok   = !sel_p1[3] && !sel_in[3];
                    enc_word = {6'b000111, is_sub, num[2:0], sel_p1[2:0], sel_in[2:0]};
                end else if (num_le255 && (sel_in == sel_p1)) begin
                    enc_ok   = !sel_in[3];
                    enc_word = {4'b0011, is_sub, sel_in[2:0], num[7:0]};
                end
            end
            UOP_LSL: begin
                enc_ok   = num_le31 && !sel_p1[3] && !sel_in[3];
                enc_word = {5'b00000, num[4:0], sel_p1[2:0], sel_in[2:0]};
            end
            UOP_MOV: begin
                enc_ok   = num_le255 && !sel_in[3];
                enc_word = {5'b00100, sel_in[2:0], num[7:0]};
            end
            UOP_CMP: begin
                enc_ok   = num_le255 && !sel_p1[3];
                enc_word = {5'b00101, sel_p1[2:0], num[7:0]};
            end
            UOP_EOR: begin
                enc_ok   = (sel_p0 == sel_in) && !sel_p1[3] && !sel_in[3];
                enc_word = {10'b0100000001, sel_p1[2:0], sel_in[2:0]};
            end
            UOP_LDR: begin
                enc_ok   = num_le31 && !sel_p1[3] && !sel_in[3];
                enc_word = {5'b01101, num[4:0], sel_p1[2:0], sel_in[2:0]};
            end
            UOP_STR: begin
                enc_ok   = num_le31 && !sel_p1[3] && !sel_p0[3];
                enc_word = {5'b01100, num[4:0], sel_p1[2:0], sel_p0[2:0]};
            end
            UOP_NOP: begin
                if (branch_cond == 4'hF) begin
                    enc_ok   = 1'b1;
                    enc_word = 16'hBF00;
                end
`ifdef ENC_BRANCH_EN
                else if (branch_cond == 4'hE) begin
                    enc_ok   = num_simm11;
                    enc_word = {5'b11100, num[10:0]};
                end else begin
                    enc_ok   = num_simm8;
                    enc_word = {4'b1101, branch_cond, num[7:0]};
                end
`endif
            end
            default: begin
                enc_ok   = 1'b0;
                enc_word = 16'h0000;
            end
        endcase
    end

    // Each FIFO entry carries {addr, instruction}.
    logic [23:0] mem_q [2];
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [7:0]  addr_cnt_q, addr_cnt_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        accept, push, pop;
    logic [23:0] head;

    assign in_ready    = (count_q != 2'd2) && !reset;
    assign out_valid   = (count_q != 2'd0) && !reset;
    assign accept      = in_valid && in_ready;
    assign push        = accept && enc_ok;
    assign pop         = out_valid && out_ready;
    assign head        = mem_q[rd_ptr_q];
    assign instruction = out_valid ? head[15:0]  : 16'h0000;
    assign addr        = out_valid ? head[23:16] : 8'h00;
    assign err         = err_q;
    assign err_count   = err_cnt_q;

    always_comb begin
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        addr_cnt_d = addr_cnt_q + {7'd0, push};
        err_d      = accept && !enc_ok;
        err_cnt_d  = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            addr_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_cnt_q <= addr_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {addr_cnt_q, enc_word};
        end
    end

endmodule
